mem_arbiter: RTL and testbench

Single-port memory arbiter between the processor's instruction-fetch stage, its load/store stage and a host loader/debug port. It serializes all three onto one 12-bit-address, 16-bit-data synchronous RAM port, issues at most one access per cycle, and returns read data to the owning requester after a fixed memory latency. It sits between the pipelined core and the shared program/data memory, so fetch and data accesses no longer need phase-multiplexed address and read/write muxing.

---
 rtl/mem_arbiter.sv | 86 ++++++++
 tb/tb_mem_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes fetch, data and host accesses onto one synchronous RAM port
// and routes read data back to the owning requester after RD_LAT cycles.
module mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 16,
  parameter int RD_LAT = 1,
  parameter int HOST_MAX_WAIT = 8
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          hold,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  input  logic          h_req,
  input  logic          h_we,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_gnt,
  output logic          h_rvalid,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] m_addr,
  output logic          m_rw,
  output logic [DW-1:0] m_data,
  input  logic [DW-1:0] m_q,
  output logic          busy
);
  localparam logic [3:0] HMW = 4'(HOST_MAX_WAIT);
  logic [3:0] cnt_q, cnt_d;
  logic [RD_LAT:0] tv_q;
  logic [1:0] to_q [RD_LAT+1];
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_data_q, m_data_d;
  logic m_rw_q, m_rw_d;
  logic en, force_h, rd, out_v;
  logic [1:0] own;
  assign en = !hold && !reset;
  assign force_h = h_req && cnt_q == HMW;
  assign d_gnt = en && d_req && !force_h;
  assign if_gnt = en && if_req && !d_req && !force_h;
  assign h_gnt = en && h_req && (force_h || (!d_req && !if_req));
  assign rd = if_gnt || (d_gnt && !d_we) || (h_gnt && !h_we);
  assign own = d_gnt ? 2'd1 : h_gnt ? 2'd2 : 2'd0;
  // pre-reset tags must never surface, even in the reset cycle itself
  assign out_v = tv_q[RD_LAT] && !reset;
  assign if_rvalid = out_v && to_q[RD_LAT] == 2'd0;
  assign d_rvalid = out_v && to_q[RD_LAT] == 2'd1;
  assign h_rvalid = out_v && to_q[RD_LAT] == 2'd2;
  assign busy = |tv_q;
  assign rdata = m_q;
  assign m_addr = m_addr_q;
  assign m_rw = m_rw_q;
  assign m_data = m_data_q;
  always_comb begin
    m_addr_d = d_gnt ? d_addr : h_gnt ? h_addr : if_gnt ? if_addr : m_addr_q;
    m_rw_d = (d_gnt && d_we) || (h_gnt && h_we);
    m_data_d = d_gnt ? d_wdata : h_gnt ? h_wdata : m_data_q;
    cnt_d = hold ? cnt_q : (h_gnt || !h_req) ? 4'd0 : (cnt_q == HMW) ? cnt_q : cnt_q + 4'd1;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
      tv_q <= '0;
      m_addr_q <= '0;
      m_rw_q <= 1'b0;
      m_data_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tv_q <= {tv_q[RD_LAT-1:0], rd};
      m_addr_q <= m_addr_d;
      m_rw_q <= m_rw_d;
      m_data_q <= m_data_d;
    end
  end
  always_ff @(posedge clock) begin
    to_q[0] <= own;
    for (int i = 1; i <= RD_LAT; i++) to_q[i] <= to_q[i-1];
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random stimulus against a queue-based model of the arbiter
// with a bench-side RAM driving m_q.
module tb_mem_arbiter;
  localparam int LAT = 2;
  localparam int HMW = 8;
  logic clock = 0, reset, hold;
  logic if_req, d_req, d_we, h_req, h_we;
  logic [11:0] if_addr, d_addr, h_addr, m_addr;
  logic [15:0] d_wdata, h_wdata, rdata, m_data, m_q;
  logic if_gnt, if_rvalid, d_gnt, d_rvalid, h_gnt, h_rvalid, m_rw, busy;
  int n_chk = 0, n_err = 0, cyc = 0;
  bit armed = 0;

  mem_arbiter #(.AW(12), .DW(16), .RD_LAT(LAT), .HOST_MAX_WAIT(HMW)) dut (
    .clock(clock), .reset(reset), .hold(hold),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_gnt(h_gnt), .h_rvalid(h_rvalid),
    .rdata(rdata), .m_addr(m_addr), .m_rw(m_rw), .m_data(m_data), .m_q(m_q), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [15:0] ram [4096];
  logic [15:0] sh [4096];
  logic [15:0] rp [LAT];
  assign m_q = rp[LAT-1];
  always @(posedge clock) begin
    if (m_rw === 1'b1) ram[m_addr] <= m_data;
    rp[0] <= ram[m_addr];
    for (int k = 1; k < LAT; k++) rp[k] <= rp[k-1];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {int due; int own; logic [15:0] dat;} ent_t;
  ent_t q[$];
  logic [11:0] em_addr;
  logic [15:0] em_data;
  logic em_rw;
  int cnt = 0;

  // reference model: 1=fetch 2=data 3=host
  always @(negedge clock) begin
    int w, rv_own;
    bit fh, we, eb;
    logic [11:0] a;
    logic [15:0] rv_dat;
    fh = h_req && cnt == HMW;
    w = (hold || reset) ? 0 : fh ? 3 : d_req ? 2 : if_req ? 1 : h_req ? 3 : 0;
    eb = q.size() != 0;
    rv_own = 0;
    rv_dat = '0;
    if (q.size() != 0 && q[0].due == cyc) begin
      if (!reset) rv_own = q[0].own;
      rv_dat = q[0].dat;
      void'(q.pop_front());
    end
    if (armed) begin
      chk("if_gnt", if_gnt, w == 1);
      chk("d_gnt", d_gnt, w == 2);
      chk("h_gnt", h_gnt, w == 3);
      chk("m_addr", m_addr, em_addr);
      chk("m_rw", m_rw, em_rw);
      chk("m_data", m_data, em_data);
      chk("busy", busy, eb);
      chk("if_rvalid", if_rvalid, rv_own == 1);
      chk("d_rvalid", d_rvalid, rv_own == 2);
      chk("h_rvalid", h_rvalid, rv_own == 3);
      if (rv_own != 0) chk("rdata", rdata, rv_dat);
    end
    if (reset) begin
      q.delete();
      em_addr = '0;
      em_rw = 0;
      em_data = '0;
      cnt = 0;
    end else begin
      if (w != 0) begin
        a = w == 1 ? if_addr : w == 2 ? d_addr : h_addr;
        we = w == 2 ? d_we : w == 3 ? h_we : 1'b0;
        em_addr = a;
        em_rw = we;
        if (w != 1) em_data = w == 2 ? d_wdata : h_wdata;
        if (we) sh[a] = em_data;
        else q.push_back('{cyc + 1 + LAT, w, sh[a]});
      end else em_rw = 0;
      cnt = hold ? cnt : (w == 3 || !h_req) ? 0 : cnt == HMW ? cnt : cnt + 1;
    end
    armed = 1;
    cyc++;
  end

  task automatic tick(); @(posedge clock); #1; endtask
  task automatic smp(); @(negedge clock); endtask
  task automatic idle();
    reset = 0; hold = 0; if_req = 0; d_req = 0; h_req = 0;
  endtask

  initial begin
    bit gi, gd, gh;
    for (int i = 0; i < 4096; i++) begin
      ram[i] = 16'($urandom);
      sh[i] = ram[i];
    end
    ram[5] = 16'h1234;
    sh[5] = 16'h1234;
    idle();
    reset = 1; d_we = 0; h_we = 0; if_addr = 0; d_addr = 0; h_addr = 0; d_wdata = 0; h_wdata = 0;
    tick(); tick();
    reset = 0;
    smp();
    chk("rst_m_rw", m_rw, 0); chk("rst_m_addr", m_addr, 0); chk("rst_busy", busy, 0);
    // fetch read of mem[5]
    tick(); if_req = 1; if_addr = 12'h005;
    smp(); chk("f_gnt", if_gnt, 1);
    tick(); if_req = 0;
    smp(); chk("f_maddr", m_addr, 12'h005); chk("f_mrw", m_rw, 0); chk("f_rv1", if_rvalid, 0);
    tick(); smp(); chk("f_rv2", if_rvalid, 0);
    tick(); smp(); chk("f_rv3", if_rvalid, 1); chk("f_rdata", rdata, 16'h1234);
    tick(); smp(); chk("f_rv4", if_rvalid, 0);
    // data write beats fetch, then read back
    tick(); d_req = 1; d_we = 1; d_addr = 12'h010; d_wdata = 16'hBEEF; if_req = 1; if_addr = 12'h001;
    smp(); chk("w_dgnt", d_gnt, 1); chk("w_ignt", if_gnt, 0);
    tick(); d_req = 0;
    smp(); chk("w_ignt2", if_gnt, 1); chk("w_mrw", m_rw, 1); chk("w_mdata", m_data, 16'hBEEF);
    tick(); if_req = 0; d_req = 1; d_we = 0;
    smp(); chk("rb_gnt", d_gnt, 1);
    tick(); d_req = 0;
    smp(); tick(); smp(); tick();
    smp(); chk("rb_rv", d_rvalid, 1); chk("rb_data", rdata, 16'hBEEF);
    // host starvation
    tick(); d_req = 1; d_addr = 12'h007; h_req = 1; h_we = 0; h_addr = 12'h009;
    for (int k = 0; k < 18; k++) begin
      smp();
      chk("st_dgnt", d_gnt, !(k == 8 || k == 17));
      chk("st_hgnt", h_gnt, k == 8 || k == 17);
      if (k < 17) tick();
    end
    tick(); idle();
    // hold with two reads in flight
    tick(); d_req = 1; d_addr = 12'h002; if_req = 1; if_addr = 12'h003; h_req = 1; h_addr = 12'h004;
    smp(); chk("h_a", d_gnt, 1);
    tick(); d_req = 0;
    smp(); chk("h_b", if_gnt, 1);
    tick(); hold = 1; d_req = 1;
    smp(); chk("h1_gnt", {if_gnt, d_gnt, h_gnt}, 0); chk("h1_mrw", m_rw, 0);
    tick(); smp(); chk("h2_drv", d_rvalid, 1); chk("h2_mrw", m_rw, 0);
    tick(); smp(); chk("h3_irv", if_rvalid, 1); chk("h3_gnt", {if_gnt, d_gnt, h_gnt}, 0);
    tick(); hold = 0;
    smp(); chk("h_after", d_gnt, 1);
    tick(); idle();
    // reset with a read in flight
    tick(); d_req = 1; d_addr = 12'h002;
    smp(); chk("r_gnt", d_gnt, 1);
    tick(); d_req = 0; reset = 1;
    smp(); chk("r_nognt", d_gnt, 0);
    tick(); reset = 0;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("r_rv", d_rvalid, 0); chk("r_busy", busy, 0); chk("r_mrw", m_rw, 0);
      if (k == 0) chk("r_maddr", m_addr, 0);
      tick();
    end
    // randomized traffic with the request-hold protocol
    for (int i = 0; i < 3000; i++) begin
      smp();
      gi = if_gnt; gd = d_gnt; gh = h_gnt;
      tick();
      reset = $urandom_range(99) == 0;
      hold = $urandom_range(9) == 0;
      if (!if_req || gi) begin if_req = 1'($urandom); if_addr = 12'($urandom_range(15)); end
      if (!d_req || gd) begin
        d_req = 1'($urandom); d_we = 1'($urandom); d_addr = 12'($urandom_range(15)); d_wdata = 16'($urandom);
      end
      if (!h_req || gh) begin
        h_req = $urandom_range(3) != 0; h_we = 1'($urandom); h_addr = 12'($urandom_range(15)); h_wdata = 16'($urandom);
      end
    end
    tick(); idle();
    repeat (6) begin smp(); tick(); end
    chk("drain", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
